// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter that shares one FIFO write port between NUM_SRC sources.
// The control path has one bubble per grant. Data, valid and ready pass through combinationally.
module fifo_write_arbiter #(
   parameter int NUM_SRC   = 4,
   parameter int WIDTH     = 32,
   parameter int IDW       = 2,
   parameter int MAX_BEATS = 16,
   parameter int CNTW      = 5
) (
   input  logic                     CLK,
   input  logic                     RESETn,
   input  logic [NUM_SRC*WIDTH-1:0] S_WDATA,
   input  logic [NUM_SRC-1:0]       S_WVALID,
   input  logic [NUM_SRC-1:0]       S_WLAST,
   output logic [NUM_SRC-1:0]       S_WREADY,
   output logic [WIDTH-1:0]         M_WDATA,
   output logic [IDW-1:0]           M_WID,
   output logic                     M_WLAST,
   output logic                     M_WVALID,
   input  logic                     M_WREADY,
   output logic                     BUSY
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state_reg, state_next;
   logic [IDW-1:0]    grant_reg, grant_next;
   logic [IDW-1:0]    last_grant_reg, last_grant_next;
   logic [CNTW-1:0]   beat_cnt_reg, beat_cnt_next;

   logic [WIDTH-1:0]  src_data [NUM_SRC];
   logic              locked;
   logic              xfer;
   logic              pick_found;
   logic [IDW-1:0]    pick;
   int                rr_idx;

   assign locked = (state_reg == LOCK);

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = S_WDATA[gi*WIDTH +: WIDTH];
      assign S_WREADY[gi] = locked && (grant_reg == IDW'(gi)) && M_WREADY;
   end

   assign M_WDATA  = src_data[grant_reg];
   assign M_WID    = grant_reg;
   assign M_WVALID = locked && S_WVALID[grant_reg];
   assign M_WLAST  = locked && (S_WLAST[grant_reg] || (beat_cnt_reg == CNTW'(MAX_BEATS - 1)));
   assign BUSY     = locked;
   assign xfer     = M_WVALID && M_WREADY;

   // Search starts just after the previous owner, so every other waiting source goes first.
   always_comb begin
      pick       = last_grant_reg;
      pick_found = 1'b0;
      rr_idx     = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         rr_idx = (int'(last_grant_reg) + k) % NUM_SRC;
         if (!pick_found && S_WVALID[rr_idx]) begin
            pick       = IDW'(rr_idx);
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      beat_cnt_next   = beat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               grant_next    = pick;
               beat_cnt_next = '0;
               state_next    = LOCK;
            end
         end
         LOCK: begin
            if (xfer) begin
               if (M_WLAST) begin
                  state_next      = IDLE;
                  last_grant_next = grant_reg;
                  beat_cnt_next   = '0;
               end else begin
                  beat_cnt_next = beat_cnt_reg + CNTW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= IDW'(NUM_SRC - 1);
         beat_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         beat_cnt_reg   <= beat_cnt_next;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: single packet, round robin, forced split, FIFO stall
// and reset in the middle of a packet.
module tb_fifo_write_arbiter;

   localparam int NUM_SRC   = 4;
   localparam int WIDTH     = 32;
   localparam int IDW       = 2;
   localparam int MAX_BEATS = 16;
   localparam int CNTW      = 5;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_SRC*WIDTH-1:0] s_wdata;
   logic [NUM_SRC-1:0]       s_wvalid;
   logic [NUM_SRC-1:0]       s_wlast;
   logic [NUM_SRC-1:0]       s_wready;
   logic [WIDTH-1:0]         m_wdata;
   logic [IDW-1:0]           m_wid;
   logic                     m_wlast;
   logic                     m_wvalid;
   logic                     m_wready;
   logic                     busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   fifo_write_arbiter #(
      .NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .IDW(IDW), .MAX_BEATS(MAX_BEATS), .CNTW(CNTW)
   ) dut (
      .CLK(clk), .RESETn(rst_n),
      .S_WDATA(s_wdata), .S_WVALID(s_wvalid), .S_WLAST(s_wlast), .S_WREADY(s_wready),
      .M_WDATA(m_wdata), .M_WID(m_wid), .M_WLAST(m_wlast), .M_WVALID(m_wvalid),
      .M_WREADY(m_wready), .BUSY(busy)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
      s_wvalid[i] = v;
      s_wlast[i]  = l;
      s_wdata[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic check_idle(input string tag);
      #1;
      check_value({tag, ".busy"}, 64'(busy), 64'd0);
      check_value({tag, ".mvalid"}, 64'(m_wvalid), 64'd0);
      check_value({tag, ".sready"}, 64'(s_wready), 64'd0);
      $display("txn %s idle", tag);
   endtask

   task automatic check_beat(input string tag, input int id, input logic [WIDTH-1:0] data,
                             input logic last);
      logic [NUM_SRC-1:0] exp_rdy;
      #1;
      exp_rdy = m_wready ? (NUM_SRC'(1) << id) : '0;
      check_value({tag, ".busy"}, 64'(busy), 64'd1);
      check_value({tag, ".mvalid"}, 64'(m_wvalid), 64'd1);
      check_value({tag, ".mid"}, 64'(m_wid), 64'(id));
      check_value({tag, ".mdata"}, 64'(m_wdata), 64'(data));
      check_value({tag, ".mlast"}, 64'(m_wlast), 64'(last));
      check_value({tag, ".sready"}, 64'(s_wready), 64'(exp_rdy));
      $display("txn %s src=%0d data=%08h last=%0b ready=%0b", tag, m_wid, m_wdata, m_wlast, m_wready);
   endtask

   initial begin
      rst_n    = 1'b0;
      s_wdata  = '0;
      s_wvalid = '0;
      s_wlast  = '0;
      m_wready = 1'b1;

      // Reset state
      #2;
      check_value("rst.busy", 64'(busy), 64'd0);
      check_value("rst.mvalid", 64'(m_wvalid), 64'd0);
      check_value("rst.mlast", 64'(m_wlast), 64'd0);
      check_value("rst.mid", 64'(m_wid), 64'd0);
      check_value("rst.sready", 64'(s_wready), 64'd0);
      tick();
      rst_n = 1'b1;

      // 1: single 3-beat packet from source 0
      drive_src(0, 1'b1, 1'b0, 32'hA000_0000);
      check_idle("t1.bubble");
      tick();
      check_beat("t1.b0", 0, 32'hA000_0000, 1'b0);
      tick();
      drive_src(0, 1'b1, 1'b0, 32'hA000_0001);
      check_beat("t1.b1", 0, 32'hA000_0001, 1'b0);
      tick();
      drive_src(0, 1'b1, 1'b1, 32'hA000_0002);
      check_beat("t1.b2", 0, 32'hA000_0002, 1'b1);
      tick();
      drive_src(0, 1'b0, 1'b0, 32'h0);
      check_idle("t1.after");

      // 2: all sources with 1-beat packets, order 0,1,2,3,0 after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) drive_src(i, 1'b1, 1'b1, 32'hB000_0000 + 32'(i));
      for (int k = 0; k < 5; k++) begin
         check_idle($sformatf("t2.g%0d.bubble", k));
         tick();
         check_beat($sformatf("t2.g%0d", k), k % NUM_SRC, 32'hB000_0000 + 32'(k % NUM_SRC), 1'b1);
         tick();
      end
      s_wvalid = '0;
      s_wlast  = '0;

      // 3: 20-beat packet on source 2 split at 16 beats, source 3 served in between
      drive_src(2, 1'b1, 1'b0, 32'hC000_0000);
      drive_src(3, 1'b1, 1'b1, 32'hD333_0003);
      check_idle("t3.bubble");
      tick();
      for (int b = 0; b < 16; b++) begin
         drive_src(2, 1'b1, 1'b0, 32'hC000_0000 + 32'(b));
         check_beat($sformatf("t3.b%0d", b), 2, 32'hC000_0000 + 32'(b), b == 15);
         tick();
      end
      drive_src(2, 1'b1, 1'b0, 32'hC000_0010);
      check_idle("t3.split");
      tick();
      check_beat("t3.src3", 3, 32'hD333_0003, 1'b1);
      tick();
      drive_src(3, 1'b0, 1'b0, 32'h0);
      check_idle("t3.bubble2");
      tick();
      for (int b = 16; b < 20; b++) begin
         drive_src(2, 1'b1, b == 19, 32'hC000_0000 + 32'(b));
         check_beat($sformatf("t3.b%0d", b), 2, 32'hC000_0000 + 32'(b), b == 19);
         tick();
      end
      drive_src(2, 1'b0, 1'b0, 32'h0);

      // 4: FIFO full for 5 cycles while source 1 owns the grant and source 3 waits
      drive_src(1, 1'b1, 1'b0, 32'hE000_0000);
      check_idle("t4.bubble");
      tick();
      drive_src(3, 1'b1, 1'b1, 32'hF333_0003);
      check_beat("t4.b0", 1, 32'hE000_0000, 1'b0);
      tick();
      drive_src(1, 1'b1, 1'b0, 32'hE000_0001);
      m_wready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         check_beat($sformatf("t4.stall%0d", s), 1, 32'hE000_0001, 1'b0);
         tick();
      end
      m_wready = 1'b1;
      check_beat("t4.b1", 1, 32'hE000_0001, 1'b0);
      tick();
      drive_src(1, 1'b1, 1'b1, 32'hE000_0002);
      check_beat("t4.b2", 1, 32'hE000_0002, 1'b1);
      tick();
      drive_src(1, 1'b0, 1'b0, 32'h0);
      check_idle("t4.bubble2");
      tick();
      check_beat("t4.src3", 3, 32'hF333_0003, 1'b1);
      tick();
      drive_src(3, 1'b0, 1'b0, 32'h0);

      // 5: reset in the middle of a source-0 packet, source 1 also waiting
      drive_src(0, 1'b1, 1'b0, 32'h6000_0000);
      drive_src(1, 1'b1, 1'b1, 32'h7111_0001);
      check_idle("t5.bubble");
      tick();
      check_beat("t5.b0", 0, 32'h6000_0000, 1'b0);
      tick();
      drive_src(0, 1'b1, 1'b0, 32'h6000_0001);
      rst_n = 1'b0;
      check_idle("t5.inreset");
      tick();
      rst_n = 1'b1;
      check_idle("t5.bubble2");
      tick();
      check_beat("t5.regrant", 0, 32'h6000_0001, 1'b0);
      tick();
      drive_src(0, 1'b1, 1'b1, 32'h6000_0002);
      check_beat("t5.b2", 0, 32'h6000_0002, 1'b1);
      tick();
      drive_src(0, 1'b0, 1'b0, 32'h0);
      check_idle("t5.bubble3");
      tick();
      check_beat("t5.src1", 1, 32'h7111_0001, 1'b1);
      tick();
      drive_src(1, 1'b0, 1'b0, 32'h0);
      check_idle("t5.end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
